input_conditioner: RTL and testbench

- Upstream conditioning stage for the four-input logic block: takes raw asynchronous board switches/pushbuttons and delivers synchronized, debounced levels that drive that block's A, B, C, D inputs.
- Also emits one-cycle rising/falling edge pulses per channel for downstream event logic.
- Four identical independent channels, single clock domain.

---
 rtl/input_conditioner_pkg.sv | 12 +
 rtl/input_conditioner_debounce_ch.sv | 52 +++++
 rtl/input_conditioner.sv | 29 ++
 tb/tb_input_conditioner.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg: shared debounce constants, FSM encodings and clog2 helper
package input_conditioner_pkg;
    localparam int DEBOUNCE_CYCLES_SYN = 500000;
    localparam int DEBOUNCE_CYCLES_SIM = 4;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] QUAL = 1'b1;
    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/input_conditioner_debounce_ch.sv
// debounce_ch: one channel of 2-flop synchronizer, qualification FSM and edge pulses
module debounce_ch
    import input_conditioner_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SYN,
    parameter logic RESET_VALUE     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_in,
    output logic sw_out,
    output logic sw_rise,
    output logic sw_fall
);
    localparam int CW = clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic          s1_q, s2_q, out_q, rise_q, fall_q;
    logic          out_d, rise_d, fall_d, diff, done;
    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        diff    = s2_q != out_q;
        done    = state_q == QUAL && cnt_q == LAST;
        state_d = (diff && !done) ? QUAL : IDLE;
        cnt_d   = state_d == IDLE ? '0 : (state_q == IDLE ? CW'(1) : cnt_q + 1'b1);
        out_d   = (diff && done) ? s2_q : out_q;
        rise_d  = out_d & ~out_q;
        fall_d  = ~out_d & out_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q    <= RESET_VALUE;
            s2_q    <= RESET_VALUE;
            out_q   <= RESET_VALUE;
            state_q <= IDLE;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= sw_in;
            s2_q    <= s1_q;
            out_q   <= out_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end
    assign sw_out  = out_q;
    assign sw_rise = rise_q;
    assign sw_fall = fall_q;
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: NCH independent debounced channels with rise/fall pulses
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int             NCH             = 4,
    parameter int             DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SYN,
    parameter logic [NCH-1:0] RESET_VALUE     = '0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] sw_in,
    output logic [NCH-1:0] sw_out,
    output logic [NCH-1:0] sw_rise,
    output logic [NCH-1:0] sw_fall
);
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_VALUE    (RESET_VALUE[i])
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .sw_in  (sw_in[i]),
            .sw_out (sw_out[i]),
            .sw_rise(sw_rise[i]),
            .sw_fall(sw_fall[i])
        );
    end
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed and random stimulus against a sliding-window debounce model
module tb_input_conditioner;
    import input_conditioner_pkg::*;
    localparam int D = DEBOUNCE_CYCLES_SIM;
    logic       clk, reset;
    logic [3:0] sw_in, sw_out, sw_rise, sw_fall;
    int         checks = 0, errors = 0;
    logic [3:0] m_s1, m_s2, m_out, m_rise, m_fall;
    logic [3:0] hist [D-1];
    int         hv;

    input_conditioner #(.NCH(4), .DEBOUNCE_CYCLES(D), .RESET_VALUE(4'b0000)) dut (
        .clk    (clk),
        .reset  (reset),
        .sw_in  (sw_in),
        .sw_out (sw_out),
        .sw_rise(sw_rise),
        .sw_fall(sw_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // An output flips once the last D synchronized samples since reset all disagree with it
    always @(posedge clk or posedge reset) begin
        logic [3:0] no;
        logic       ok;
        if (reset) begin
            m_s1 <= '0; m_s2 <= '0; m_out <= '0; m_rise <= '0; m_fall <= '0; hv <= 0;
        end else begin
            no = m_out;
            for (int i = 0; i < 4; i++) begin
                ok = (hv >= D - 1) && (m_s2[i] != m_out[i]);
                for (int j = 0; j < D - 1; j++) if (hist[j][i] == m_out[i]) ok = 1'b0;
                if (ok) no[i] = ~m_out[i];
            end
            m_rise <= no & ~m_out;
            m_fall <= ~no & m_out;
            m_out  <= no;
            hist[0] <= m_s2;
            for (int j = 1; j < D - 1; j++) hist[j] <= hist[j-1];
            hv   <= (hv < D - 1) ? hv + 1 : hv;
            m_s2 <= m_s1;
            m_s1 <= sw_in;
        end
    end

    always @(negedge clk) begin
        check("out", 32'(sw_out), 32'(m_out));
        check("rise", 32'(sw_rise), 32'(m_rise));
        check("fall", 32'(sw_fall), 32'(m_fall));
        check("excl", 32'(sw_rise & sw_fall), 32'd0);
    end

    task automatic watch(input int ch, output int lat, output int r, output int f);
        logic p;
        p = sw_out[ch];
        lat = -1; r = 0; f = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (lat < 0 && sw_out[ch] !== p) lat = k;
            r += int'(sw_rise[ch]);
            f += int'(sw_fall[ch]);
        end
    endtask

    task automatic step(input int n, input int ch, output int r, output int f);
        r = 0; f = 0;
        repeat (n) begin
            @(negedge clk);
            r += int'(sw_rise[ch]);
            f += int'(sw_fall[ch]);
        end
    endtask

    initial begin
        int lat, r, f, r2, f2, hold;
        reset = 1'b1;
        sw_in = 4'b0000;
        repeat (3) @(negedge clk);
        sw_in = 4'b1111;
        #2 reset = 1'b0;
        watch(3, lat, r, f);
        check("rel_lat", 32'(lat), 32'd5);
        check("rel_rise", 32'(r), 32'd1);
        check("rel_fall", 32'(f), 32'd0);
        check("rel_out", 32'(sw_out), 32'hF);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_out", 32'(sw_out), 32'd0);
        check("async_rise", 32'(sw_rise), 32'd0);
        check("async_fall", 32'(sw_fall), 32'd0);
        @(negedge clk);
        sw_in = 4'b0000;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        sw_in[0] = 1'b1;
        watch(0, lat, r, f);
        check("press_lat", 32'(lat), 32'd5);
        check("press_rise", 32'(r), 32'd1);
        check("press_fall", 32'(f), 32'd0);
        @(negedge clk);
        sw_in[2] = 1'b1;
        step(3, 2, r, f);
        sw_in[2] = 1'b0;
        step(2, 2, r2, f2);
        check("bounce_pulses", 32'(r + f + r2 + f2), 32'd0);
        check("bounce_out", 32'(sw_out[2]), 32'd0);
        sw_in[2] = 1'b1;
        watch(2, lat, r, f);
        check("bounce_lat", 32'(lat), 32'd5);
        check("bounce_rise", 32'(r), 32'd1);
        @(negedge clk);
        sw_in[0] = 1'b0;
        watch(0, lat, r, f);
        check("release_lat", 32'(lat), 32'd5);
        check("release_fall", 32'(f), 32'd1);
        check("release_rise", 32'(r), 32'd0);
        @(negedge clk);
        sw_in = 4'b0000;
        repeat (8) @(negedge clk);
        sw_in = 4'b1010;
        repeat (5) @(posedge clk);
        #1 check("simul_early", 32'(sw_out), 32'd0);
        @(posedge clk);
        #1;
        check("simul_out", 32'(sw_out), 32'hA);
        check("simul_rise", 32'(sw_rise), 32'hA);
        check("simul_fall", 32'(sw_fall), 32'd0);
        @(posedge clk);
        #1 check("simul_once", 32'(sw_rise), 32'd0);
        @(negedge clk);
        sw_in = 4'b1000;
        repeat (8) @(negedge clk);
        sw_in[1] = 1'b1;
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        watch(1, lat, r, f);
        check("midrst_lat", 32'(lat), 32'd5);
        check("midrst_rise", 32'(r), 32'd1);
        @(negedge clk);
        repeat (60) begin
            sw_in = sw_in ^ 4'($urandom);
            hold = $urandom_range(1, 8);
            repeat (hold) @(negedge clk);
            if ($urandom_range(0, 9) == 0) begin
                #2 reset = 1'b1;
                #1 reset = 1'b0;
            end
        end
        repeat (10) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
